// File: rtl/uart_cmd_pkg.sv
// uart_cmd_pkg: shared types and constants for the UART command sequencer
package uart_cmd_pkg;
  typedef enum logic [2:0] {IDLE, CHECK, EXEC, SEND, WAIT_DONE} state_t;
  localparam int RESP_W = 8;
  localparam int OK_BIT = RESP_W - 1;
  localparam int STATUS_ADDR_DEF = 7;
  localparam int TX_TIMEOUT_DEF = 20000;
  localparam logic RW_READ = 1'b1;
  localparam logic RW_WRITE = 1'b0;
  function automatic logic parity_ok(input logic [RESP_W:0] frame);
    return ~^frame;
  endfunction
endpackage

// File: rtl/uart_cmd_if.sv
// uart_cmd_if: decoded frame input and transmitter start/busy/done handshake
interface uart_cmd_if import uart_cmd_pkg::*; #(
  parameter int ADDR_W = 3,
  parameter int DATA_W = 4
);
  logic frame_valid;
  logic frame_rw;
  logic [ADDR_W-1:0] frame_addr;
  logic [DATA_W-1:0] frame_data;
  logic frame_parity;
  logic tx_busy;
  logic tx_done;
  logic tx_start;
  logic [RESP_W-1:0] tx_data;
  modport master (
    output frame_valid, frame_rw, frame_addr, frame_data, frame_parity, tx_busy, tx_done,
    input tx_start, tx_data
  );
  modport slave (
    input frame_valid, frame_rw, frame_addr, frame_data, frame_parity, tx_busy, tx_done,
    output tx_start, tx_data
  );
endinterface

// File: rtl/uart_cmd_regbank.sv
// uart_cmd_regbank: register bank with one sync write port and one comb read port
module uart_cmd_regbank import uart_cmd_pkg::*; #(
  parameter int ADDR_W = 3,
  parameter int DATA_W = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [2**ADDR_W];
  always_ff @(posedge clk)
    if (!rst) mem <= '{default: '0};
    else if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/uart_cmd_ctrl.sv
// uart_cmd_ctrl: parity-checked command executor driving a one-byte UART response
module uart_cmd_ctrl import uart_cmd_pkg::*; #(
  parameter int ADDR_W = 3,
  parameter int DATA_W = 4,
  parameter int TX_TIMEOUT = TX_TIMEOUT_DEF,
  parameter int STATUS_ADDR = STATUS_ADDR_DEF
) (
  input  logic clk,
  input  logic rst,
  uart_cmd_if.slave bus,
  output logic busy,
  output logic parity_err,
  output logic overrun,
  output logic tx_timeout
);
  localparam int CNT_W = $clog2(TX_TIMEOUT + 1);
  state_t state;
  logic f_rw, f_par, ok;
  logic [ADDR_W-1:0] f_addr;
  logic [DATA_W-1:0] f_data, rdata, payload, status_word;
  logic [CNT_W-1:0] cnt;
  logic [RESP_W-1:0] resp, resp_next;
  logic is_status, status_wr, we, stat_rd, to_hit;
  uart_cmd_regbank #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_regs (
    .clk(clk), .rst(rst), .we(we), .waddr(f_addr), .wdata(f_data), .raddr(f_addr), .rdata(rdata)
  );
  always_comb begin
    is_status = f_addr == ADDR_W'(STATUS_ADDR);
    status_wr = f_rw == RW_WRITE && is_status;
    we = state == EXEC && ok && f_rw == RW_WRITE && !is_status;
    stat_rd = state == EXEC && ok && f_rw == RW_READ && is_status;
    status_word = DATA_W'({overrun, parity_err, tx_timeout, 1'b0});
    payload = !ok || status_wr ? '0 : f_rw == RW_WRITE ? f_data : is_status ? status_word : rdata;
    to_hit = state == WAIT_DONE && !bus.tx_done && cnt == CNT_W'(TX_TIMEOUT - 1);
    resp_next = '0;
    resp_next[OK_BIT] = ok && !status_wr;
    resp_next[DATA_W +: ADDR_W] = f_addr;
    resp_next[DATA_W-1:0] = payload;
  end
  // tx_start must see tx_busy in the same cycle to hit the N+3 latency
  assign bus.tx_start = state == SEND && !bus.tx_busy;
  assign bus.tx_data = resp;
  assign busy = state != IDLE;
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      f_rw <= 1'b0;
      f_par <= 1'b0;
      f_addr <= '0;
      f_data <= '0;
      ok <= 1'b0;
      cnt <= '0;
      resp <= '0;
      parity_err <= 1'b0;
      overrun <= 1'b0;
      tx_timeout <= 1'b0;
    end else begin
      // a new set event beats a status-read clear in the same cycle
      overrun <= (bus.frame_valid && state != IDLE) || (overrun && !stat_rd);
      parity_err <= (state == EXEC && !ok) || (parity_err && !stat_rd);
      tx_timeout <= to_hit || (tx_timeout && !stat_rd);
      case (state)
        IDLE:
          if (bus.frame_valid) begin
            f_rw <= bus.frame_rw;
            f_addr <= bus.frame_addr;
            f_data <= bus.frame_data;
            f_par <= bus.frame_parity;
            state <= CHECK;
          end
        CHECK: begin
          ok <= parity_ok({f_rw, f_addr, f_data, f_par});
          state <= EXEC;
        end
        EXEC: begin
          resp <= resp_next;
          state <= SEND;
        end
        SEND:
          if (!bus.tx_busy) begin
            cnt <= '0;
            state <= WAIT_DONE;
          end
        WAIT_DONE:
          if (bus.tx_done || to_hit) state <= IDLE;
          else cnt <= cnt + 1'b1;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// tb_uart_cmd_ctrl: scoreboard bench for the UART command sequencer
module tb_uart_cmd_ctrl;
  localparam int TO = 64;
  logic clk = 1'b0;
  logic rst;
  logic busy, parity_err, overrun, tx_timeout;
  int total = 0;
  int bad = 0;
  int starts = 0;
  logic [7:0] exp_q[$];
  logic [7:0] exp_v;
  logic [3:0] m_reg [8];
  always #5 clk = ~clk;
  uart_cmd_if #(.ADDR_W(3), .DATA_W(4)) bus ();
  uart_cmd_ctrl #(.ADDR_W(3), .DATA_W(4), .TX_TIMEOUT(TO), .STATUS_ADDR(7)) dut (
    .clk(clk), .rst(rst), .bus(bus), .busy(busy),
    .parity_err(parity_err), .overrun(overrun), .tx_timeout(tx_timeout)
  );
  always @(negedge clk)
    if (rst === 1'b1 && bus.tx_start === 1'b1) begin
      starts++;
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL tx_data: unexpected tx_start, got=%h", bus.tx_data);
      end else begin
        exp_v = exp_q.pop_front();
        if (bus.tx_data !== exp_v) begin
          bad++;
          $display("FAIL tx_data: got=%h want=%h", bus.tx_data, exp_v);
        end
      end
    end
  function automatic logic ep(input logic rw, input logic [2:0] a, input logic [3:0] d);
    return ^{rw, a, d};
  endfunction
  task automatic send(input logic rw, input logic [2:0] a, input logic [3:0] d, input logic p);
    @(posedge clk); #1;
    bus.frame_rw = rw;
    bus.frame_addr = a;
    bus.frame_data = d;
    bus.frame_parity = p;
    bus.frame_valid = 1'b1;
    @(posedge clk); #1;
    bus.frame_valid = 1'b0;
  endtask
  task automatic wait_start(output int lat);
    lat = 0;
    for (int i = 1; i <= 200 && lat == 0; i++) begin
      @(negedge clk);
      if (bus.tx_start === 1'b1) lat = i;
    end
    if (lat == 0) begin
      total++;
      bad++;
      $display("FAIL start_wait: no tx_start within 200 cycles, queued=%0d want=0", exp_q.size());
      exp_q.delete();
    end
  endtask
  task automatic finish_tx();
    @(posedge clk); #1;
    bus.tx_done = 1'b1;
    @(posedge clk); #1;
    bus.tx_done = 1'b0;
  endtask
  task automatic do_frame(input logic rw, input logic [2:0] a, input logic [3:0] d, input logic p,
                          input logic [7:0] e);
    int lat;
    exp_q.push_back(e);
    send(rw, a, d, p);
    wait_start(lat);
    total++;
    if (lat !== 3) begin
      bad++;
      $display("FAIL latency: got=%0d want=3", lat);
    end
    finish_tx();
    @(negedge clk);
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL idle_after_done: busy=%b want=0", busy);
    end
  endtask
  task automatic test_reset();
    rst = 1'b0;
    bus.frame_valid = 1'b0;
    bus.frame_rw = 1'b0;
    bus.frame_addr = '0;
    bus.frame_data = '0;
    bus.frame_parity = 1'b0;
    bus.tx_busy = 1'b0;
    bus.tx_done = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total += 3;
    if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got=%b want=0", busy); end
    if (bus.tx_start !== 1'b0 || bus.tx_data !== 8'h00) begin
      bad++;
      $display("FAIL reset_tx: start=%b data=%h want 0/00", bus.tx_start, bus.tx_data);
    end
    if ({overrun, parity_err, tx_timeout} !== 3'b000) begin
      bad++;
      $display("FAIL reset_flags: got=%b want=000", {overrun, parity_err, tx_timeout});
    end
    #1 rst = 1'b1;
  endtask
  task automatic test_write();
    do_frame(1'b0, 3'b110, 4'b1101, 1'b1, 8'hED);
    total++;
    if ({overrun, parity_err, tx_timeout} !== 3'b000) begin
      bad++;
      $display("FAIL write_flags: got=%b want=000", {overrun, parity_err, tx_timeout});
    end
  endtask
  task automatic test_read();
    do_frame(1'b1, 3'b010, 4'b1010, 1'b0, 8'hA0);
    do_frame(1'b0, 3'b010, 4'b0101, 1'b1, 8'hA5);
    do_frame(1'b1, 3'b010, 4'b0000, 1'b0, 8'hA5);
  endtask
  task automatic test_parity();
    do_frame(1'b0, 3'b110, 4'b1101, 1'b0, 8'h60);
    total++;
    if (parity_err !== 1'b1) begin bad++; $display("FAIL parity_set: got=%b want=1", parity_err); end
    do_frame(1'b1, 3'b110, 4'b0000, 1'b1, 8'hED);
    do_frame(1'b1, 3'b111, 4'b0000, 1'b0, 8'hF4);
    total++;
    if (parity_err !== 1'b0) begin bad++; $display("FAIL parity_clear: got=%b want=0", parity_err); end
  endtask
  task automatic test_overrun();
    int base, lat;
    bus.tx_busy = 1'b1;
    exp_q.push_back(8'hB9);
    base = starts;
    send(1'b0, 3'b011, 4'b1001, ep(1'b0, 3'b011, 4'b1001));
    repeat (2) @(posedge clk);
    send(1'b0, 3'b011, 4'b0001, ep(1'b0, 3'b011, 4'b0001));
    @(negedge clk);
    total += 2;
    if (overrun !== 1'b1) begin bad++; $display("FAIL overrun_set: got=%b want=1", overrun); end
    if (busy !== 1'b1 || starts != base) begin
      bad++;
      $display("FAIL backpressure_hold: busy=%b starts=%0d want 1/%0d", busy, starts, base);
    end
    repeat (3) @(posedge clk);
    #1 bus.tx_busy = 1'b0;
    wait_start(lat);
    finish_tx();
    repeat (4) @(negedge clk);
    total++;
    if (starts - base != 1) begin bad++; $display("FAIL single_start: got=%0d want=1", starts - base); end
    do_frame(1'b1, 3'b011, 4'b0000, 1'b1, 8'hB9);
    do_frame(1'b1, 3'b111, 4'b0000, 1'b0, 8'hF8);
    total++;
    if (overrun !== 1'b0) begin bad++; $display("FAIL overrun_clear: got=%b want=0", overrun); end
  endtask
  task automatic test_timeout();
    int lat;
    exp_q.push_back(8'h94);
    send(1'b0, 3'b001, 4'b0100, 1'b0);
    wait_start(lat);
    for (int i = 1; i <= TO + 1; i++) begin
      @(negedge clk);
      if (i == TO) begin
        total++;
        if (tx_timeout !== 1'b0 || busy !== 1'b1) begin
          bad++;
          $display("FAIL timeout_early: flag=%b busy=%b want 0/1", tx_timeout, busy);
        end
      end
      if (i == TO + 1) begin
        total++;
        if (tx_timeout !== 1'b1 || busy !== 1'b0) begin
          bad++;
          $display("FAIL timeout_set: flag=%b busy=%b want 1/0", tx_timeout, busy);
        end
      end
    end
    do_frame(1'b1, 3'b001, 4'b0000, 1'b0, 8'h94);
    do_frame(1'b1, 3'b111, 4'b0000, 1'b0, 8'hF2);
    total++;
    if (tx_timeout !== 1'b0) begin bad++; $display("FAIL timeout_clear: got=%b want=0", tx_timeout); end
  endtask
  task automatic test_reset_mid();
    int lat;
    do_frame(1'b0, 3'b101, 4'b0111, 1'b1, 8'hD7);
    exp_q.push_back(8'hD7);
    send(1'b1, 3'b101, 4'b0000, 1'b1);
    wait_start(lat);
    send(1'b1, 3'b000, 4'b0000, 1'b1);
    total++;
    if (overrun !== 1'b1) begin bad++; $display("FAIL mid_overrun: got=%b want=1", overrun); end
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    total++;
    if ({busy, bus.tx_start, overrun, parity_err, tx_timeout} !== 5'b0 || bus.tx_data !== 8'h00) begin
      bad++;
      $display("FAIL mid_reset: outs=%b data=%h want 00000/00",
               {busy, bus.tx_start, overrun, parity_err, tx_timeout}, bus.tx_data);
    end
    do_frame(1'b1, 3'b101, 4'b0000, 1'b1, 8'hD0);
  endtask
  task automatic test_status_write();
    do_frame(1'b0, 3'b111, 4'b0101, 1'b1, 8'h70);
    total++;
    if ({overrun, parity_err, tx_timeout} !== 3'b000) begin
      bad++;
      $display("FAIL status_write_flags: got=%b want=000", {overrun, parity_err, tx_timeout});
    end
    do_frame(1'b1, 3'b111, 4'b0000, 1'b0, 8'hF0);
  endtask
  task automatic test_back_to_back();
    logic rw;
    logic [2:0] a;
    logic [3:0] d;
    for (int i = 0; i < 8; i++) m_reg[i] = 4'h0;
    for (int i = 0; i < 12; i++) begin
      rw = 1'($urandom_range(0, 1));
      a = 3'($urandom_range(0, 6));
      d = 4'($urandom);
      if (rw) do_frame(rw, a, d, ep(rw, a, d), {1'b1, a, m_reg[a]});
      else begin
        do_frame(rw, a, d, ep(rw, a, d), {1'b1, a, d});
        m_reg[a] = d;
      end
    end
  endtask
  initial begin
    test_reset();
    test_write();
    test_read();
    test_parity();
    test_overrun();
    test_timeout();
    test_reset_mid();
    test_status_write();
    test_back_to_back();
    total++;
    if (exp_q.size() != 0) begin bad++; $display("FAIL leftover: got=%0d want=0", exp_q.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
